// File: rtl/vga_pkg.sv
// Default raster timing constants for the VGA display path (640x480 @ 60 Hz,
// 25 MHz pixel clock). Sprite mappers reuse these for their scaling math.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync pulse windows: [start, end)
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= val < hi.
  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with asynchronous active-low reset to a
// parameterised value. DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int                 WIDTH     = 1,
  parameter int                 DEPTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = vga_clk ^ reset_n;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift din through DEPTH stages; reset loads RESET_VAL everywhere.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RESET_VAL;
          end
        end else begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: scan counters, active-video qualifier and
// active-low syncs delayed to match the mappers' RGB latency.
// Optional macro VGA_FRAME_CNT_EN adds an 8-bit frame_count output used for
// sprite animation stepping.
module vga_timing_gen #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       frame_start,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0] frame_count,
`endif
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_r;
  logic [9:0] vc_r;
  logic       line_start_r;
  logic       frame_start_r;
  logic       blank_s;
  logic       hs_s;
  logic       vs_s;
  logic [2:0] dly_in_s;
  logic [2:0] dly_out_s;

  // Scan counters plus wrap flags; flags are set on the wrapping edge so they
  // line up with the (0,y)/(0,0) cycle, never with the post-reset start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_r          <= 10'd0;
      vc_r          <= 10'd0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (hc_r == H_LAST) begin
      hc_r         <= 10'd0;
      line_start_r <= 1'b1;
      if (vc_r == V_LAST) begin
        vc_r          <= 10'd0;
        frame_start_r <= 1'b1;
      end else begin
        vc_r          <= vc_r + 10'd1;
        frame_start_r <= 1'b0;
      end
    end else begin
      hc_r          <= hc_r + 10'd1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter steps together with the frame_start flag, wrapping 255->0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= 8'd0;
    end else if ((hc_r == H_LAST) && (vc_r == V_LAST)) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_count = frame_cnt_r;
`endif

  // Raw, zero-latency video qualifier and active-low syncs from the counters.
  always_comb begin
    blank_s  = (hc_r < H_ACT) && (vc_r < V_ACT);
    hs_s     = ~vga_pkg::in_window(hc_r, H_SS, H_SE);
    vs_s     = ~vga_pkg::in_window(vc_r, V_SS, V_SE);
    dly_in_s = {hs_s, vs_s, blank_s};
  end

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b111)
  ) u_sync_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .din     (dly_in_s),
    .dout    (dly_out_s)
  );

  assign DrawX       = hc_r;
  assign DrawY       = vc_r;
  assign blank       = blank_s;
  assign hs_d        = dly_out_s[2];
  assign vs_d        = dly_out_s[1];
  assign blank_d     = dly_out_s[0];
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Instance a uses default 640x480 timing
// with SYNC_DELAY=2; instance b uses a tiny 8x6 raster with SYNC_DELAY=0 so
// whole frames (and frame_count wrap) fit in a short run.
module tb_vga_timing_gen;

  logic       vga_clk;
  logic       reset_n;

  logic [9:0] drawx_a, drawy_a, drawx_b, drawy_b;
  logic       blank_a, hs_d_a, vs_d_a, blank_d_a, fs_a, ls_a;
  logic       blank_b, hs_d_b, vs_d_b, blank_d_b, fs_b, ls_b;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc_a, fc_b;
`endif

  int checks = 0;
  int errors = 0;
  int ls_cnt_a = 0;
  int fs_cnt_b = 0;
  int vs_low_b = 0;

  vga_timing_gen #(.SYNC_DELAY(2)) dut_a (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (drawx_a),
    .DrawY       (drawy_a),
    .blank       (blank_a),
    .hs_d        (hs_d_a),
    .vs_d        (vs_d_a),
    .blank_d     (blank_d_a),
    .frame_start (fs_a),
`ifdef VGA_FRAME_CNT_EN
    .frame_count (fc_a),
`endif
    .line_start  (ls_a)
  );

  // Tiny raster: H 4/1/2/1 (total 8, hs low hc 5..6), V 3/1/1/1 (total 6, vs low vc 4)
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_DELAY(0)
  ) dut_b (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (drawx_b),
    .DrawY       (drawy_b),
    .blank       (blank_b),
    .hs_d        (hs_d_b),
    .vs_d        (vs_d_b),
    .blank_d     (blank_d_b),
    .frame_start (fs_b),
`ifdef VGA_FRAME_CNT_EN
    .frame_count (fc_b),
`endif
    .line_start  (ls_b)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare both instances against hand-derived values for cycle c after reset release.
  task automatic check_cycle(input int c);
    int ha, va, hp, vp, hb, vb;
    logic ehs, evs, ebd;
    ha = c % 800;
    va = (c / 800) % 525;
    chk("a_drawx", {22'd0, drawx_a}, ha);
    chk("a_drawy", {22'd0, drawy_a}, va);
    chk("a_blank", {31'd0, blank_a}, ((ha < 640) && (va < 480)) ? 1 : 0);
    chk("a_line_start", {31'd0, ls_a}, ((c > 0) && (ha == 0)) ? 1 : 0);
    chk("a_frame_start", {31'd0, fs_a}, ((c > 0) && (c % 420000 == 0)) ? 1 : 0);
    if (c >= 2) begin
      hp  = (c - 2) % 800;
      vp  = ((c - 2) / 800) % 525;
      ehs = !((hp >= 656) && (hp < 752));
      evs = !((vp >= 490) && (vp < 492));
      ebd = (hp < 640) && (vp < 480);
    end else begin
      ehs = 1'b1;
      evs = 1'b1;
      ebd = 1'b1;
    end
    chk("a_hs_d", {31'd0, hs_d_a}, {31'd0, ehs});
    chk("a_vs_d", {31'd0, vs_d_a}, {31'd0, evs});
    chk("a_blank_d", {31'd0, blank_d_a}, {31'd0, ebd});

    hb = c % 8;
    vb = (c / 8) % 6;
    chk("b_drawx", {22'd0, drawx_b}, hb);
    chk("b_drawy", {22'd0, drawy_b}, vb);
    chk("b_blank", {31'd0, blank_b}, ((hb < 4) && (vb < 3)) ? 1 : 0);
    chk("b_hs_d", {31'd0, hs_d_b}, ((hb >= 5) && (hb < 7)) ? 0 : 1);
    chk("b_vs_d", {31'd0, vs_d_b}, (vb == 4) ? 0 : 1);
    chk("b_blank_d", {31'd0, blank_d_b}, ((hb < 4) && (vb < 3)) ? 1 : 0);
    chk("b_line_start", {31'd0, ls_b}, ((c > 0) && (hb == 0)) ? 1 : 0);
    chk("b_frame_start", {31'd0, fs_b}, ((c > 0) && (c % 48 == 0)) ? 1 : 0);
`ifdef VGA_FRAME_CNT_EN
    chk("a_frame_count", {24'd0, fc_a}, 0);
    chk("b_frame_count", {24'd0, fc_b}, (c / 48) % 256);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    // Reset state
    chk("rst_a_drawx", {22'd0, drawx_a}, 0);
    chk("rst_a_drawy", {22'd0, drawy_a}, 0);
    chk("rst_a_blank", {31'd0, blank_a}, 1);
    chk("rst_a_hs_d", {31'd0, hs_d_a}, 1);
    chk("rst_a_vs_d", {31'd0, vs_d_a}, 1);
    chk("rst_a_blank_d", {31'd0, blank_d_a}, 1);
    chk("rst_a_frame_start", {31'd0, fs_a}, 0);
    chk("rst_a_line_start", {31'd0, ls_a}, 0);

    // Phase 1: first line and a half of default timing
    reset_n = 1'b1;
    check_cycle(0);
    for (int c = 1; c <= 1500; c++) begin
      @(posedge vga_clk);
      #1;
      if ((c <= 800) && (ls_a === 1'b1)) ls_cnt_a++;
      check_cycle(c);
    end
    chk("a_line_start_pulses_first_line", ls_cnt_a, 1);
    // Here hc=700 on line 1, so hs_d is low before the reset hits
    chk("a_hs_d_low_before_reset", {31'd0, hs_d_a}, 0);

    // Asynchronous reset mid-line: outputs clear without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_a_drawx", {22'd0, drawx_a}, 0);
    chk("async_a_drawy", {22'd0, drawy_a}, 0);
    chk("async_a_hs_d", {31'd0, hs_d_a}, 1);
    chk("async_a_vs_d", {31'd0, vs_d_a}, 1);
    chk("async_a_blank_d", {31'd0, blank_d_a}, 1);
    chk("async_b_drawx", {22'd0, drawx_b}, 0);
    chk("async_b_drawy", {22'd0, drawy_b}, 0);
    @(posedge vga_clk);
    #1;
    chk("held_a_drawx", {22'd0, drawx_a}, 0);

    // Phase 2: restart from (0,0); 257 small frames for frame wrap and frame_count
    reset_n = 1'b1;
    check_cycle(0);
    for (int c = 1; c <= 257 * 48 + 5; c++) begin
      @(posedge vga_clk);
      #1;
      if ((c <= 48) && (fs_b === 1'b1)) fs_cnt_b++;
      if ((c <= 48) && (vs_d_b === 1'b0)) vs_low_b++;
      check_cycle(c);
    end
    chk("b_frame_start_pulses_one_frame", fs_cnt_b, 1);
    chk("b_vs_low_cycles_one_frame", vs_low_b, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
